// File: rtl/div_16bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_16bit_seq
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_RUN  = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             w_div_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_div_zero = (divisor == '0);
  // The restored remainder is always below D, so the partial remainder's top
  // bit is only ever meaningful inside the shifted trial value.
  assign w_shift    = {r_q, q_q[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, d_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (count_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          count_d = '0;
          if (w_div_zero) begin
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!w_trial[WIDTH]) begin
          r_d = w_trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = w_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        // Results are published on the edge entering DONE so they are stable with done.
        if (count_q == LAST) begin
          quot_d = q_d;
          rem_d  = r_d;
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_16bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_16bit_seq
// Description : Self-checking bench for div_16bit_seq using an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_16bit_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_16bit_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: cycle index of each clock interval; an op accepted on the edge
  // opening interval A is busy through A+16 (A for divide by zero), done in
  // that last interval, and publishes plain-arithmetic results there.
  int unsigned  cyc = 0;
  logic         m_active = 1'b0;
  int unsigned  m_done_cyc = 0;
  logic [W-1:0] m_q = '0, m_r = '0, m_nq = '0, m_nr = '0;
  logic         m_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_q      <= '0;
      m_r      <= '0;
      m_z      <= 1'b0;
    end else if (!(m_active && cyc <= m_done_cyc) && start) begin
      m_active <= 1'b1;
      if (divisor == '0) begin
        m_done_cyc <= cyc + 1;
        m_q        <= '1;
        m_r        <= dividend;
        m_z        <= 1'b1;
      end else begin
        m_done_cyc <= cyc + 17;
        m_nq       <= dividend / divisor;
        m_nr       <= dividend % divisor;
      end
    end else if (m_active && cyc + 1 == m_done_cyc) begin
      m_q <= m_nq;
      m_r <= m_nr;
      m_z <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",        busy,        m_active && cyc <= m_done_cyc);
      chk("done",        done,        m_active && cyc == m_done_cyc);
      chk("quotient",    quotient,    m_q);
      chk("remainder",   remainder,   m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int lat, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ez, input string tag);
    int n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done seen"},   done,        1);
    chk({tag, " latency"},     n,           lat);
    chk({tag, " quotient"},    quotient,    eq);
    chk({tag, " remainder"},   remainder,   er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy",      busy,        0);
    chk("reset done",      done,        0);
    chk("reset quotient",  quotient,    0);
    chk("reset remainder", remainder,   0);
    chk("reset dbz",       div_by_zero, 0);
    rst_n = 1'b1;

    launch(16'd100, 16'd7);
    chk("100/7 busy after accept", busy, 1);
    wait_done(1, 17, 16'd14, 16'd2, 1'b0, "100/7");
    launch(16'hFFFF, 16'h0001);
    wait_done(1, 17, 16'hFFFF, 16'h0000, 1'b0, "FFFF/1");
    launch(16'hFFFF, 16'hFFFF);
    wait_done(1, 17, 16'h0001, 16'h0000, 1'b0, "FFFF/FFFF");
    launch(16'd3, 16'd10);
    wait_done(1, 17, 16'd0, 16'd3, 1'b0, "3/10");
    launch(16'h8000, 16'h0003);
    wait_done(1, 17, 16'h2AAA, 16'h0002, 1'b0, "8000/3");
    launch(16'd5, 16'd0);
    wait_done(1, 1, 16'hFFFF, 16'd5, 1'b1, "5/0");
    launch(16'd9, 16'd3);
    wait_done(1, 17, 16'd3, 16'd0, 1'b0, "9/3");

    // Start re-pulsed mid-operation must be ignored
    launch(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(6, 17, 16'd14, 16'd2, 1'b0, "100/7 repulse");

    // Start held through DONE: next accept only after one IDLE cycle
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    wait_done(1, 17, 16'd3, 16'd0, 1'b0, "held first");
    @(negedge clk);
    chk("held idle gap busy", busy, 0);
    @(negedge clk);
    chk("held second accept busy", busy, 1);
    start = 1'b0;
    wait_done(1, 17, 16'd3, 16'd0, 1'b0, "held second");

    // Asynchronous reset in the middle of an op
    launch(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy",      busy,        0);
    chk("midreset done",      done,        0);
    chk("midreset quotient",  quotient,    0);
    chk("midreset remainder", remainder,   0);
    chk("midreset dbz",       div_by_zero, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midreset no done", done, 0);
    end
    rst_n = 1'b1;
    launch(16'd20, 16'd6);
    wait_done(1, 17, 16'd3, 16'd2, 1'b0, "20/6");

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1:       divisor = W'($urandom_range(1, 15));
        default: divisor = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
